// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the add/sub arbiter: FSM encoding, op codes and
// the requester-index width helper.
package addsub_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // ceil(log2(n)), never less than 1 so a single requester still gets a 1-bit id
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/addsub_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching cyclically.
module rr_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  // k is the distance from ptr; j is only ever used as a direct index
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_any    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!grant_any && req[j] && (j == ((int'(ptr) + k) % N_REQ))) begin
          grant_any       = 1'b1;
          grant_onehot[j] = 1'b1;
          grant_idx       = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one external combinational add/sub unit among N_REQ requesters with
// round-robin arbitration and registered operands/result.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter  int N_BITS = 32,
  parameter  int N_REQ  = 4,
  localparam int ID_W   = clog2_min1(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*N_BITS-1:0] req_a,
  input  logic [N_REQ*N_BITS-1:0] req_b,
  input  logic [N_REQ-1:0]        req_op,
  output logic [N_BITS-1:0]       alu_a,
  output logic [N_BITS-1:0]       alu_b,
  output logic                    alu_sel,
  input  logic [N_BITS-1:0]       alu_out,
  input  logic                    alu_carry,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [N_BITS-1:0]       rsp_data,
  output logic                    rsp_carry,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg;
  logic [ID_W-1:0]   g_reg;
  logic [N_BITS-1:0] a_reg, b_reg;
  logic              op_reg;
  logic [N_BITS-1:0] rsp_data_reg;
  logic              rsp_carry_reg;
  logic [ID_W-1:0]   rsp_id_reg;

  logic [N_BITS-1:0] a_arr [N_REQ];
  logic [N_BITS-1:0] b_arr [N_REQ];
  logic [N_REQ-1:0]  grant_onehot;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic [ID_W-1:0]   ptr_inc;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*N_BITS +: N_BITS];
    assign b_arr[gi] = req_b[gi*N_BITS +: N_BITS];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req          (req_valid),
    .ptr          (ptr_reg),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_any    (grant_any)
  );

  // next pointer skips past the requester that just completed
  assign ptr_inc = (g_reg == ID_W'(N_REQ - 1)) ? '0 : g_reg + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_reg == IDLE) ? grant_onehot : '0;
    rsp_valid = (state_reg == RESP);
    busy      = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      g_reg         <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= OP_ADD;
      rsp_data_reg  <= '0;
      rsp_carry_reg <= 1'b0;
      rsp_id_reg    <= '0;
    end else begin
      if (state_reg == IDLE && grant_any) begin
        a_reg  <= a_arr[grant_idx];
        b_reg  <= b_arr[grant_idx];
        op_reg <= req_op[grant_idx];
        g_reg  <= grant_idx;
      end
      if (state_reg == EXEC) begin
        rsp_data_reg  <= alu_out;
        rsp_carry_reg <= alu_carry;
        rsp_id_reg    <= g_reg;
      end
      if (state_reg == RESP && rsp_ready) ptr_reg <= ptr_inc;
    end
  end

  // operands stay on the unit between operations; only the EXEC capture matters
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_sel   = (op_reg == OP_SUB);
  assign rsp_data  = rsp_data_reg;
  assign rsp_carry = rsp_carry_reg;
  assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_addsub_arbiter;

  localparam int NB = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*NB-1:0]  req_a, req_b;
  logic [NR-1:0]     req_op;
  logic [NB-1:0]     alu_a, alu_b, alu_out;
  logic              alu_sel, alu_carry;
  logic              rsp_valid, rsp_ready;
  logic [NB-1:0]     rsp_data;
  logic              rsp_carry;
  logic [IW-1:0]     rsp_id;
  logic              busy;

  logic [NB-1:0]     a_v [NR];
  logic [NB-1:0]     b_v [NR];

  int checks = 0;
  int errors = 0;

  assign req_a = {a_v[3], a_v[2], a_v[1], a_v[0]};
  assign req_b = {b_v[3], b_v[2], b_v[1], b_v[0]};

  always #5 clk = ~clk;

  // the shared add/sub unit the arbiter drives
  always_comb begin
    if (alu_sel) {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    else         {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
  end

  addsub_arbiter #(.N_BITS(NB), .N_REQ(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int            m_stage;   // 0 free, 1 operation accepted, 2 result held
  int            m_ptr, m_g, m_id;
  logic [NB-1:0] m_a, m_b, m_data;
  logic          m_op, m_carry;
  logic          started = 1'b0;
  logic [NR-1:0] accepted_mask = '0;
  logic [NR-1:0] pend = '0;
  logic [NB-1:0] pa [NR];
  logic [NB-1:0] pb [NR];
  logic [NR-1:0] pop;

  always @(negedge clk) begin
    int g;
    logic [NR-1:0] exp_ready;
    logic [32:0] s;
    g = -1;
    exp_ready = '0;
    if (m_stage == 0)
      for (int k = 0; k < NR; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    if (g >= 0) exp_ready[g] = 1'b1;

    if (started) begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          checks++;
          if (!req_valid[i] || a_v[i] !== pa[i] || b_v[i] !== pb[i] || req_op[i] !== pop[i]) begin
            errors++;
            $display("FAIL protocol req%0d changed before accept at %0t", i, $time);
          end
        end
      end
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, m_stage != 0);
      chk("rsp_valid", rsp_valid, m_stage == 2);
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_carry", rsp_carry, m_carry);
      chk("rsp_id", rsp_id, m_id);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_sel", alu_sel, m_op);
      if (m_stage == 2 && rsp_ready && rst_n)
        $display("rsp id=%0d data=%08h carry=%0d t=%0t", m_id, m_data, m_carry, $time);
    end

    accepted_mask = rst_n ? (req_valid & req_ready) : '0;
    pend = req_valid & ~accepted_mask;
    for (int i = 0; i < NR; i++) begin
      pa[i] = a_v[i];
      pb[i] = b_v[i];
      pop[i] = req_op[i];
    end

    if (!rst_n) begin
      started = 1'b1;
      m_stage = 0; m_ptr = 0; m_g = 0; m_id = 0;
      m_a = '0; m_b = '0; m_op = 1'b0; m_data = '0; m_carry = 1'b0;
    end else begin
      case (m_stage)
        0: if (g >= 0) begin
             m_a = a_v[g]; m_b = b_v[g]; m_op = req_op[g]; m_g = g; m_stage = 1;
           end
        1: begin
             if (m_op) begin
               m_data  = m_a - m_b;
               m_carry = (m_a >= m_b);
             end else begin
               s = {1'b0, m_a} + {1'b0, m_b};
               m_data  = s[31:0];
               m_carry = s[32];
             end
             m_id = m_g;
             m_stage = 2;
           end
        default: if (rsp_ready) begin
             m_ptr = (m_g + 1) % NR;
             m_stage = 0;
           end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int i, input logic [NB-1:0] a, input logic [NB-1:0] b, input logic op);
    a_v[i] = a;
    b_v[i] = b;
    req_op[i] = op;
    req_valid[i] = 1'b1;
  endtask

  task automatic drain_idle();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while ((req_valid != '0 || busy) && n < 100) begin
      tick();
      req_valid = req_valid & ~accepted_mask;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL drain_timeout got busy=%0d valid=%0h required idle", busy, req_valid);
    end
  endtask

  task automatic do_single(input int i, input logic [NB-1:0] a, input logic [NB-1:0] b,
                           input logic op, input logic [NB-1:0] ed, input logic ec);
    logic [NR-1:0] oh;
    oh = 4'b0001 << i;
    tick();
    present(i, a, b, op);
    @(negedge clk);
    chk("dir_grant", req_ready, oh);
    tick();
    req_valid[i] = 1'b0;
    @(negedge clk);
    chk("dir_exec_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    chk("dir_rsp_valid", rsp_valid, 1);
    chk("dir_rsp_data", rsp_data, ed);
    chk("dir_rsp_carry", rsp_carry, ec);
    chk("dir_rsp_id", rsp_id, i);
  endtask

  function automatic logic [NB-1:0] rnd();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [NR-1:0] e;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_op = '0;
    for (int i = 0; i < NR; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_alu_a", alu_a, 0);

    // single add and subtract, then ptr should sit at 3
    do_single(0, 32'd2, 32'd3, 1'b0, 32'd5, 1'b0);
    do_single(2, 32'd50, 32'd20, 1'b1, 32'd30, 1'b1);
    tick();
    present(0, 32'd100, 32'd1, 1'b0);
    present(3, 32'd7, 32'd7, 1'b1);
    @(negedge clk);
    chk("ptr_after_req2", req_ready, 4'b1000);
    drain_idle();

    // wrap-around arithmetic
    do_single(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1);
    do_single(3, 32'd1, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // consumer stall in the result state
    tick();
    rsp_ready = 1'b0;
    present(0, 32'd7, 32'd8, 1'b0);
    @(negedge clk);
    chk("stall_grant", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    present(1, 32'd9, 32'd9, 1'b1);
    tick();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_data", rsp_data, 32'd15);
      chk("stall_rsp_id", rsp_id, 0);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", rsp_valid, 1);
    tick();
    @(negedge clk);
    chk("stall_next_grant", req_ready, 4'b0010);
    drain_idle();

    // all four requesting continuously after reset
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) present(i, 32'(i * 10 + 1), 32'(i), 1'(i % 2));
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      e = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      chk("rr_order", req_ready, e);
      tick();
    end
    drain_idle();

    // reset while an operation is executing
    tick();
    present(2, 32'd11, 32'd4, 1'b0);
    @(negedge clk);
    chk("midrst_grant", req_ready, 4'b0100);
    tick();
    req_valid[2] = 1'b0;
    rst_n = 1'b0;
    present(0, 32'd5, 32'd5, 1'b0);
    present(2, 32'd6, 32'd1, 1'b1);
    @(negedge clk);
    chk("midrst_busy", busy, 1);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy_clear", busy, 0);
    chk("midrst_grant_from0", req_ready, 4'b0001);
    drain_idle();

    // randomized traffic, checked every cycle by the model process
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      rst_n = ($urandom_range(0, 199) != 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || accepted_mask[i]) begin
          if ($urandom_range(0, 9) < 4) present(i, rnd(), rnd(), 1'($urandom_range(0, 1)));
          else req_valid[i] = 1'b0;
        end
      end
    end
    rst_n = 1'b1;
    drain_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
